// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand-issue / divide sequencer:
//   WIDTH      datapath width of the attached 32-bit ALU
//   ITER       number of shift/subtract divide iterations (one per bit)
//   ALU_DIV    ALU instruction code that selects one divide iteration
//   FLG_*      bit positions inside the 4-bit flag vectors
//   state_e    sequencer state encoding
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;

    localparam logic [3:0] ALU_DIV = 4'd6;

    localparam int FLG_OVF = 0;
    localparam int FLG_C   = 1;
    localparam int FLG_Z   = 2;
    localparam int FLG_DZ  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_div_sequencer.sv
// ----------------------------------------------------------------------------
// alu_div_sequencer
// Registers an operation request and drives the combinational 32-bit ALU that
// sits beside this block. Single-pass ops use one ALU cycle; divide runs 32
// shift/subtract iterations with the partial remainder fed back through A and
// the dividend/quotient shifted through DI/DO.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   START               request strobe, only sampled in IDLE
//   OP, OPA, OPB, CIN   request: instruction, operands, carry-in
//   BUSY                high whenever not IDLE
//   DONE                one-cycle completion pulse
//   RESULT, REM         Z (or quotient) and remainder; held until next result
//   FLAGS_OUT           {divzero, zero, carry, ovf}
//   ALU_A/B/DI/INST/CI/FIRSTCYC   drive the ALU inputs (all 0 in IDLE/FIN)
//   ALU_Z, ALU_DO, ALU_FLAGS      ALU results returned in the same cycle
// ----------------------------------------------------------------------------
module alu_div_sequencer
    import alu_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] REM,
    output logic [3:0]       FLAGS_OUT,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [WIDTH-1:0] ALU_DI,
    output logic [3:0]       ALU_INST,
    output logic             ALU_CI,
    output logic             ALU_FIRSTCYC,
    input  logic [WIDTH-1:0] ALU_Z,
    input  logic [WIDTH-1:0] ALU_DO,
    input  logic [3:0]       ALU_FLAGS
);

    localparam int                CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;       // dividend shifting out, quotient shifting in
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;   // carry from the previous iteration
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   rem_out_q, rem_out_d;
    logic [3:0]         flags_q, flags_d;

    // The ALU's bit 3 carries no meaning for this block.
    logic unused_alu_flag3;
    assign unused_alu_flag3 = ALU_FLAGS[FLG_DZ];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            rem_out_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            result_q  <= result_d;
            rem_out_q <= rem_out_d;
            flags_q   <= flags_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        result_d     = result_q;
        rem_out_d    = rem_out_q;
        flags_d      = flags_q;
        ALU_A        = '0;
        ALU_B        = '0;
        ALU_DI       = '0;
        ALU_INST     = '0;
        ALU_CI       = 1'b0;
        ALU_FIRSTCYC = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    op_d  = OP;
                    a_d   = OPA;
                    b_d   = OPB;
                    cin_d = CIN;
                    if (OP != ALU_DIV) begin
                        state_d = EXEC;
                    end else if (OPB != '0) begin
                        state_d = DIV;
                        rem_d   = '0;
                        quo_d   = OPA;
                        cnt_d   = '0;
                        carry_d = 1'b0;
                    end else begin
                        // Divide by zero never touches the ALU: finish at once
                        // with the conventional all-ones quotient.
                        state_d          = FIN;
                        result_d         = '1;
                        rem_out_d        = OPA;
                        flags_d          = '0;
                        flags_d[FLG_DZ]  = 1'b1;
                    end
                end
            end

            EXEC: begin
                ALU_A        = a_q;
                ALU_B        = b_q;
                ALU_INST     = op_q;
                ALU_CI       = cin_q;
                ALU_FIRSTCYC = 1'b1;
                result_d     = ALU_Z;
                rem_out_d    = '0;
                flags_d      = {1'b0, ALU_FLAGS[FLG_Z:FLG_OVF]};
                state_d      = FIN;
            end

            DIV: begin
                ALU_A        = rem_q;
                ALU_B        = b_q;
                ALU_DI       = quo_q;
                ALU_INST     = ALU_DIV;
                ALU_CI       = carry_q;
                ALU_FIRSTCYC = (cnt_q == '0);
                rem_d        = ALU_Z;
                quo_d        = ALU_DO;
                carry_d      = ALU_FLAGS[FLG_C];
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Publish straight from the ALU so the final iteration's
                    // values are visible in FIN without an extra cycle.
                    state_d         = FIN;
                    result_d        = ALU_DO;
                    rem_out_d       = ALU_Z;
                    flags_d         = '0;
                    flags_d[FLG_Z]  = (ALU_Z == '0);
                    flags_d[FLG_C]  = ALU_FLAGS[FLG_C];
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BUSY      = (state_q != IDLE);
    assign DONE      = (state_q == FIN);
    assign RESULT    = result_q;
    assign REM       = rem_out_q;
    assign FLAGS_OUT = flags_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_div_sequencer
// Drives the sequencer against a behavioural model of the attached ALU and
// checks completions against a scoreboard of expected results.
// ----------------------------------------------------------------------------
module tb_alu_div_sequencer;

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] d;
        logic [3:0]  fl;
    } alu_out_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        logic [3:0]  flg;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [3:0]  OP;
    logic [31:0] OPA, OPB;
    logic        CIN;
    logic        BUSY, DONE;
    logic [31:0] RESULT, REM;
    logic [3:0]  FLAGS_OUT;
    logic [31:0] ALU_A, ALU_B, ALU_DI;
    logic [3:0]  ALU_INST;
    logic        ALU_CI, ALU_FIRSTCYC;
    logic [31:0] ALU_Z, ALU_DO;
    logic [3:0]  ALU_FLAGS;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    alu_div_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
        .CIN(CIN), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .REM(REM),
        .FLAGS_OUT(FLAGS_OUT), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_DI(ALU_DI),
        .ALU_INST(ALU_INST), .ALU_CI(ALU_CI), .ALU_FIRSTCYC(ALU_FIRSTCYC),
        .ALU_Z(ALU_Z), .ALU_DO(ALU_DO), .ALU_FLAGS(ALU_FLAGS)
    );

    // Golden ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 6 divide step,
    // 8 add with carry-in; anything else passes A.
    function automatic alu_out_t gold(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] di,
                                      input logic ci);
        alu_out_t r;
        logic [32:0] s;
        logic q;
        r = '0;
        s = '0;
        q = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r.z = s[31:0]; r.fl[1] = s[32];
                r.fl[0] = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r.z = s[31:0]; r.fl[1] = s[32];
                r.fl[0] = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'd2: r.z = a & b;
            4'd3: r.z = a | b;
            4'd4: r.z = a ^ b;
            4'd6: begin
                s = {a, di[31]};
                if (s >= {1'b0, b}) begin
                    s = s - {1'b0, b};
                    q = 1'b1;
                end
                r.z = s[31:0];
                r.d = {di[30:0], q};
                r.fl[1] = q;
            end
            4'd8: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
                r.z = s[31:0]; r.fl[1] = s[32];
                r.fl[0] = (a[31] == b[31]) && (s[31] != a[31]);
            end
            default: r.z = a;
        endcase
        r.fl[2] = (r.z == 32'd0);
        return r;
    endfunction

    alu_out_t alu_m;
    always_comb alu_m = gold(ALU_INST, ALU_A, ALU_B, ALU_DI, ALU_CI);
    assign ALU_Z     = alu_m.z;
    assign ALU_DO    = alu_m.d;
    assign ALU_FLAGS = alu_m.fl;

    function automatic exp_t expect_of(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic ci);
        exp_t e;
        alu_out_t g;
        logic [31:0] q, r;
        if (op == 4'd6) begin
            if (b == 32'd0) begin
                e.res = 32'hFFFF_FFFF; e.rem = a; e.flg = 4'b1000;
            end else begin
                q = a / b;
                r = a % b;
                e.res = q; e.rem = r; e.flg = {1'b0, (r == 32'd0), q[0], 1'b0};
            end
        end else begin
            g = gold(op, a, b, 32'd0, ci);
            e.res = g.z; e.rem = 32'd0; e.flg = {1'b0, g.fl[2:0]};
        end
        return e;
    endfunction

    // Issues one request, pushes its expectation and watches until DONE.
    // lat = 0 means DONE never arrived. inj_at > 0 pulses a foreign START
    // in that cycle of the operation.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input int inj_at,
                          output int lat, output int busy_cnt, output int fc_cnt,
                          output int fc_first, output int ci_err);
        logic prev_c;
        lat = 0; busy_cnt = 0; fc_cnt = 0; fc_first = -1; ci_err = 0; prev_c = 1'b0;
        @(negedge CLK);
        OP = op; OPA = a; OPB = b; CIN = ci; START = 1'b1;
        sb.push_back(expect_of(op, a, b, ci));
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
            if (cyc == inj_at) begin
                START = 1'b1; OP = 4'd0; OPA = 32'h1111_1111; OPB = 32'h2222_2222;
            end
            if (BUSY) busy_cnt++;
            if (BUSY && ALU_INST == 4'd6) begin
                if (ALU_FIRSTCYC) begin
                    fc_cnt++;
                    if (fc_first < 0) fc_first = cyc;
                end
                if (ALU_CI !== prev_c) ci_err++;
                prev_c = ALU_FLAGS[1];
            end
            if (DONE) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 1'b0; OP = '0; OPA = '0; OPB = '0; CIN = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({BUSY, DONE} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done got %b want 00", {BUSY, DONE});
        end
        checks++;
        if ({RESULT, REM, FLAGS_OUT} !== '0) begin
            errors++; $display("FAIL reset_results got %h/%h/%b want 0", RESULT, REM, FLAGS_OUT);
        end
        checks++;
        if ({ALU_A, ALU_B, ALU_DI, ALU_INST, ALU_CI, ALU_FIRSTCYC} !== '0) begin
            errors++; $display("FAIL reset_alu_drive got %h %h %h %h want 0", ALU_A, ALU_B, ALU_DI, ALU_INST);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL idle_busy got %b want 0", BUSY);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_single();
        int lat, bc, fc, ff, ce;
        exp_t e;
        run_op(4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 0, lat, bc, fc, ff, ce);
        e = sb.pop_front();
        checks++;
        if (lat != 2) begin errors++; $display("FAIL single_latency got %0d want 2", lat); end
        checks++;
        if (bc != 2) begin errors++; $display("FAIL single_busy got %0d want 2", bc); end
        checks++;
        if (RESULT !== e.res) begin errors++; $display("FAIL single_result got %h want %h", RESULT, e.res); end
        checks++;
        if (REM !== e.rem) begin errors++; $display("FAIL single_rem got %h want %h", REM, e.rem); end
        checks++;
        if (FLAGS_OUT !== e.flg) begin errors++; $display("FAIL single_flags got %b want %b", FLAGS_OUT, e.flg); end
        $display("single: op=8 result=%h flags=%b lat=%0d", RESULT, FLAGS_OUT, lat);
    endtask

    task automatic test_divide();
        int lat, bc, fc, ff, ce;
        exp_t e;
        run_op(4'd6, 32'd100, 32'd7, 1'b0, 0, lat, bc, fc, ff, ce);
        e = sb.pop_front();
        checks++;
        if (lat != 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
        checks++;
        if (bc != 33) begin errors++; $display("FAIL div_busy got %0d want 33", bc); end
        checks++;
        if (RESULT !== 32'd14 || RESULT !== e.res) begin errors++; $display("FAIL div_quot got %0d want 14", RESULT); end
        checks++;
        if (REM !== 32'd2 || REM !== e.rem) begin errors++; $display("FAIL div_rem got %0d want 2", REM); end
        checks++;
        if (FLAGS_OUT !== e.flg) begin errors++; $display("FAIL div_flags got %b want %b", FLAGS_OUT, e.flg); end
        checks++;
        if (fc != 1 || ff != 1) begin errors++; $display("FAIL div_firstcyc got count %0d at %0d want 1 at 1", fc, ff); end
        checks++;
        if (ce != 0) begin errors++; $display("FAIL div_carry_chain got %0d bad CI want 0", ce); end
        $display("divide: 100/7 q=%0d r=%0d lat=%0d", RESULT, REM, lat);
    endtask

    task automatic test_divzero();
        int lat, bc, fc, ff, ce;
        exp_t e;
        run_op(4'd6, 32'h1234_5678, 32'd0, 1'b0, 0, lat, bc, fc, ff, ce);
        e = sb.pop_front();
        checks++;
        if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
        checks++;
        if (RESULT !== e.res) begin errors++; $display("FAIL dz_result got %h want %h", RESULT, e.res); end
        checks++;
        if (REM !== e.rem) begin errors++; $display("FAIL dz_rem got %h want %h", REM, e.rem); end
        checks++;
        if (FLAGS_OUT !== e.flg) begin errors++; $display("FAIL dz_flags got %b want %b", FLAGS_OUT, e.flg); end
        $display("divzero: result=%h rem=%h flags=%b", RESULT, REM, FLAGS_OUT);
    endtask

    task automatic test_start_while_busy();
        int lat, bc, fc, ff, ce, extra;
        exp_t e;
        run_op(4'd6, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 11, lat, bc, fc, ff, ce);
        e = sb.pop_front();
        checks++;
        if (lat != 33) begin errors++; $display("FAIL busy_start_latency got %0d want 33", lat); end
        checks++;
        if (RESULT !== e.res) begin errors++; $display("FAIL busy_start_quot got %h want %h", RESULT, e.res); end
        checks++;
        if (REM !== e.rem) begin errors++; $display("FAIL busy_start_rem got %h want %h", REM, e.rem); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL busy_start_second_done got %0d want 0", extra); end
        $display("start_while_busy: q=%h r=%h extra_done=%0d", RESULT, REM, extra);
    endtask

    task automatic test_reset_mid_divide();
        int lat, bc, fc, ff, ce, dones;
        exp_t e;
        @(negedge CLK);
        OP = 4'd6; OPA = 32'h8765_4321; OPB = 32'd3; START = 1'b1;
        sb.push_back(expect_of(4'd6, 32'h8765_4321, 32'd3, 1'b0));
        @(negedge CLK);   // iteration 0 in progress
        START = 1'b0;
        repeat (20) @(negedge CLK);  // iteration 20 in progress
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, RESULT, REM, FLAGS_OUT} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got %b%b %h %h %b want 0", BUSY, DONE, RESULT, REM, FLAGS_OUT);
        end
        checks++;
        if ({ALU_A, ALU_B, ALU_DI, ALU_INST, ALU_CI, ALU_FIRSTCYC} !== '0) begin
            errors++; $display("FAIL rst_mid_alu got %h %h %h %h want 0", ALU_A, ALU_B, ALU_DI, ALU_INST);
        end
        e = sb.pop_front();  // aborted, never completes
        dones = 0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        RST_N = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", dones); end
        run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, lat, bc, fc, ff, ce);
        e = sb.pop_front();
        checks++;
        if (lat != 33) begin errors++; $display("FAIL rst_after_latency got %0d want 33", lat); end
        checks++;
        if (RESULT !== 32'hFFFF_FFFF || RESULT !== e.res) begin errors++; $display("FAIL rst_after_quot got %h want ffffffff", RESULT); end
        checks++;
        if (REM !== 32'd0) begin errors++; $display("FAIL rst_after_rem got %h want 0", REM); end
        checks++;
        if (FLAGS_OUT !== e.flg) begin errors++; $display("FAIL rst_after_flags got %b want %b", FLAGS_OUT, e.flg); end
        $display("reset_mid_divide: then ffffffff/1 q=%h r=%h", RESULT, REM);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4] = '{4'd0, 4'd1, 4'd4, 4'd8};
        logic [31:0] as  [4] = '{32'h7FFF_FFFF, 32'h0000_0005, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'h0000_0001, 32'h0000_0009, 32'h5A5A_5A5A, 32'h0000_0000};
        logic [31:0] held;
        int t, last_done;
        bit seen;
        exp_t e;
        held = RESULT;
        t = 0;
        last_done = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            t++;
            OP = ops[i]; OPA = as[i]; OPB = bs[i]; CIN = 1'b1; START = 1'b1;
            sb.push_back(expect_of(ops[i], as[i], bs[i], 1'b1));
            seen = 1'b0;
            for (int w = 0; w < 6; w++) begin
                @(negedge CLK);
                t++;
                START = 1'b0;
                if (DONE) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    checks++;
                    if (RESULT !== e.res || FLAGS_OUT !== e.flg) begin
                        errors++; $display("FAIL b2b_result[%0d] got %h/%b want %h/%b", i, RESULT, FLAGS_OUT, e.res, e.flg);
                    end
                    if (last_done >= 0) begin
                        checks++;
                        if (t - last_done != 3) begin
                            errors++; $display("FAIL b2b_interval[%0d] got %0d want 3", i, t - last_done);
                        end
                    end
                    last_done = t;
                    held = e.res;
                    $display("back_to_back[%0d]: op=%0d result=%h at t=%0d", i, ops[i], RESULT, t);
                    break;
                end else begin
                    checks++;
                    if (RESULT !== held) begin
                        errors++; $display("FAIL b2b_hold[%0d] got %h want %h", i, RESULT, held);
                    end
                end
            end
            if (!seen) begin
                checks++; errors++;
                $display("FAIL b2b_timeout[%0d] got no DONE want DONE", i);
                void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_divide();
        test_divzero();
        test_start_while_busy();
        test_reset_mid_divide();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
